load_store_unit: RTL and testbench

- Sits between the CPU execute stage and the 128-word data memory.
- Converts byte-addressed byte, half-word and word loads and stores into the memory's word-only interface: 7-bit word address, one write enable, registered read data.
- Sub-word stores are done by read-modify-write. Loads are sign- or zero-extended.
- Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-only data memory.
// Optional saturating error counter output enabled by defining LSU_ERR_CNT_EN.
module load_store_unit #(
    parameter int MEM_AW = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_we2,
    input  logic [31:0]       mem_read_data
`ifdef LSU_ERR_CNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, DONE} state_t;

    state_t            state, next_state;
    logic [MEM_AW+1:0] addr_q;
    logic [1:0]        size_q;
    logic              store_q;
    logic              unsigned_q;
    logic              err_q;
    logic [15:0]       wdata_q;
    logic [31:0]       merge_q;

    logic              accept;
    logic              acc_err;
    logic [4:0]        lane_shift;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    assign accept      = req_valid & req_ready;
    assign mem_address = addr_q[MEM_AW+1:2];

    // Rejected requests never reach the memory, so the check uses the live request.
    always_comb begin
        acc_err = 1'b0;
        if (req_size == 2'b11)
            acc_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            acc_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        if (req_addr[31:MEM_AW+2] != '0)
            acc_err = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_err        = 1'b0;
        mem_we2        = 1'b0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_err)
                        next_state = DONE;
                    else if (req_store && req_size == 2'b10)
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:  next_state = MRG;
            MRG: next_state = store_q ? WR : DONE;
            WR: begin
                mem_we2        = 1'b1;
                mem_write_data = merge_q;
                next_state     = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_err    = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        lane_byte  = mem_read_data[lane_shift +: 8];
        lane_half  = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_val = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_val = mem_read_data;
        endcase
        merge_val = mem_read_data;
        if (size_q == 2'b00)
            merge_val[lane_shift +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merge_val[31:16] = wdata_q;
        else
            merge_val[15:0] = wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            size_q     <= '0;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rsp_rdata  <= '0;
        end else if (accept) begin
            addr_q     <= req_addr[MEM_AW+1:0];
            size_q     <= req_size;
            store_q    <= req_store;
            unsigned_q <= req_unsigned;
            err_q      <= acc_err;
            wdata_q    <= req_wdata[15:0];
            merge_q    <= req_wdata;
        end else if (state == MRG) begin
            if (store_q)
                merge_q <= merge_val;
            else
                rsp_rdata <= load_val;
        end
    end

`ifdef LSU_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else if (state == DONE && err_q && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural registered-read data memory.
module tb_load_store_unit;

    localparam int MEM_AW = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [MEM_AW-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_we2;
    logic [31:0]       mem_read_data;
`ifdef LSU_ERR_CNT_EN
    logic [15:0]       err_count;
`endif

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          we_count = 0;
    logic [MEM_AW-1:0] last_we_addr;
    logic [31:0] last_we_data;
    logic        mem_clear;
    logic [31:0] mem [0:127];
    logic [31:0] ref_mem [0:127];
    logic [31:0] ref_rdata;
    int          ref_errs;

    load_store_unit #(.MEM_AW(MEM_AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_rdata      (rsp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_we2        (mem_we2),
        .mem_read_data  (mem_read_data)
`ifdef LSU_ERR_CNT_EN
        ,
        .err_count      (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= '0;
            mem_read_data <= '0;
        end else if (mem_we2)
            mem[mem_address] <= mem_write_data;
        else
            mem_read_data <= mem[mem_address];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard and checks error, data and latency.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we2) begin
                we_count++;
                last_we_addr = mem_address;
                last_we_data = mem_write_data;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0)
                    check_output("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
                else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    check_output({e.tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
                    check_output({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                    check_output({e.tag, "_lat"}, 32'(cyc - a), 32'(e.lat));
                end
            end
        end
    end

    task automatic predict(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        logic        bad;
        logic [31:0] word, shifted, mask;
        int          sh, idx;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd512);
        sh  = 8 * int'(a[1:0]);
        idx = int'(a[8:2]);
        e.tag = tag;
        e.err = bad;
        if (bad) begin
            e.lat = 1;
            if (ref_errs < 65535) ref_errs++;
        end else if (st) begin
            if (sz == 2'd2) begin
                ref_mem[idx] = wd;
                e.lat = 2;
            end else begin
                mask = ((sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
                e.lat = 4;
            end
        end else begin
            word    = ref_mem[idx];
            shifted = word >> sh;
            if (sz == 2'd0)
                ref_rdata = uns ? (shifted & 32'hFF) : 32'($signed(shifted[7:0]));
            else if (sz == 2'd1)
                ref_rdata = uns ? (shifted & 32'hFFFF) : 32'($signed(shifted[15:0]));
            else
                ref_rdata = word;
            e.lat = 3;
        end
        e.rdata = ref_rdata;
    endtask

    // Drives one request and returns once it has been accepted; req_valid stays high.
    task automatic apply_stimulus(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd, input bit track,
                                  output int waits, output int acc_cyc);
        exp_t e;
        @(negedge clk);
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        if (track) begin
            predict(tag, st, sz, uns, a, wd, e);
            exp_q.push_back(e);
        end
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready)
            check_output({tag, "_accept_timeout"}, {31'b0, req_ready}, 32'd1);
        acc_cyc = cyc;
        if (track) acc_q.push_back(acc_cyc);
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int t;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check_output("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
        int w, ac;
        apply_stimulus(tag, st, sz, uns, a, wd, 1'b1, w, ac);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          w1, w2, a1, a2, we0;
        logic [31:0] saved;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        ref_rdata    = '0;
        ref_errs     = 0;
        reset        = 1'b0;
        mem_clear    = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        check_output("rst_ready",   {31'b0, req_ready}, 32'd1);
        check_output("rst_valid",   {31'b0, rsp_valid}, 32'd0);
        check_output("rst_err",     {31'b0, rsp_err},   32'd0);
        check_output("rst_rdata",   rsp_rdata,          32'd0);
        check_output("rst_we",      {31'b0, mem_we2},   32'd0);
        check_output("rst_addr",    32'(mem_address),   32'd0);
        check_output("rst_wdata",   mem_write_data,     32'd0);
        mem_clear = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Word store then word load.
        we0 = we_count;
        run_one("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check_output("st_w_we_count", 32'(we_count - we0), 32'd1);
        check_output("st_w_we_addr",  32'(last_we_addr),   32'd4);
        check_output("st_w_we_data",  last_we_data,        32'hDEADBEEF);
        run_one("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Byte store and signed/unsigned byte loads.
        run_one("st_b", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5);
        check_output("st_b_mem", mem[4], 32'hDEADA5EF);
        run_one("ld_bs", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        check_output("ld_bs_val", rsp_rdata, 32'hFFFFFFA5);
        run_one("ld_bu", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check_output("ld_bu_val", rsp_rdata, 32'h000000A5);

        // Half store and signed/unsigned half loads.
        run_one("st_h", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
        check_output("st_h_mem", mem[4], 32'h8001A5EF);
        run_one("ld_hs", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check_output("ld_hs_val", rsp_rdata, 32'hFFFF8001);
        run_one("ld_hu", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        check_output("ld_hu_val", rsp_rdata, 32'h00008001);

        // Rejected accesses: no memory write, rsp_rdata unchanged.
        we0 = we_count;
        run_one("e_wmis",  1'b0, 2'b10, 1'b0, 32'h13,  32'h0);
        run_one("e_hmis",  1'b1, 2'b01, 1'b0, 32'h11,  32'h1234);
        run_one("e_size",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0);
        run_one("e_range", 1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
        check_output("err_no_we", 32'(we_count - we0), 32'd0);
        check_output("err_mem",   mem[4], 32'h8001A5EF);
`ifdef LSU_ERR_CNT_EN
        check_output("err_count4", 32'(err_count), 32'd4);
`endif

        // Back-to-back loads with req_valid held high.
        apply_stimulus("q1", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, w1, a1);
        apply_stimulus("q2", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, w2, a2);
        check_output("q2_ready_low", 32'(w2), 32'd3);
        check_output("q2_gap",       32'(a2 - a1), 32'd4);
        wait_idle();

        // Random mix over the low words, including illegal sizes and ranges.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? (32'h200 + $urandom_range(0, 63)) : 32'($urandom_range(0, 63));
            run_one("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ra, $urandom);
        end
        for (int i = 0; i < 16; i++)
            check_output("rnd_mem", mem[i], ref_mem[i]);
`ifdef LSU_ERR_CNT_EN
        check_output("err_count_total", 32'(err_count), 32'(ref_errs));
`endif

        // Reset while a byte store is in RD abandons it.
        saved = mem[4];
        apply_stimulus("rst_mid", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000FF, 1'b0, w1, a1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_output("mid_ready", {31'b0, req_ready}, 32'd1);
        check_output("mid_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("mid_we",    {31'b0, mem_we2},   32'd0);
        check_output("mid_rdata", rsp_rdata,          32'd0);
        repeat (3) @(negedge clk);
        check_output("mid_mem", mem[4], saved);
`ifdef LSU_ERR_CNT_EN
        check_output("mid_err_count", 32'(err_count), 32'd0);
`endif
        reset     = 1'b1;
        ref_rdata = '0;
        ref_errs  = 0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        run_one("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
